// File: rtl/dmem_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// dmem_mmio_ctrl - byte RAM, address-0 push/pop stack and pass/fail/timeout
// status register on the RV32IMC_3P data port.            Rev 1.0
// ============================================================================
module dmem_mmio_ctrl #(
  parameter int          ADDR_W      = 20,
  parameter int          STACK_DEPTH = 16,
  parameter logic [31:0] STATUS_ADDR = 32'h1001200C,
  parameter logic [31:0] PASS_CODE   = 32'h00400000,
  parameter logic [31:0] FAIL_CODE   = 32'h00080000,
  parameter int          PASS_NEEDED = 2,
  parameter int          TIMEOUT     = 3200000
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         c_dmem_store,
  input  logic [2:0]                   dmem_store_width,
  input  logic [31:0]                  dmem_store_data,
  input  logic [32:0]                  dmem_store_addr,
  input  logic                         c_dmem_load,
  input  logic [32:0]                  dmem_load_addr,
  output logic [31:0]                  dmem_load_data,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                         stack_ovf,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic                         timeout,
  output logic [31:0]                  cycle_cnt
);

  localparam int                c_SP_W    = $clog2(STACK_DEPTH) + 1;
  localparam int                c_IDX_W   = c_SP_W - 1;
  localparam int                c_PC_W    = $clog2(PASS_NEEDED + 1);
  localparam logic [c_SP_W-1:0] c_FULL    = c_SP_W'(STACK_DEPTH);
  localparam logic [c_PC_W-1:0] c_PC_LAST = c_PC_W'(PASS_NEEDED - 1);
  localparam logic [31:0]       c_TO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PASS = 2'd1,
    S_FAIL = 2'd2,
    S_TOUT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [c_SP_W-1:0]   sp_q, sp_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         cyc_q, cyc_d;
  logic [c_PC_W-1:0]   pcnt_q, pcnt_d;

  logic [7:0]          mem_q [2**ADDR_W];
  logic [31:0]         stk_q [STACK_DEPTH];

  logic [31:0]         w_sa, w_la;
  logic                w_run, w_st_stk, w_st_stat, w_ld_stk, w_ld_stat;
  logic                w_push, w_pop, w_ram_we, w_stat_we, w_full, w_empty;
  logic                w_pass_tok, w_fail_tok;
  logic [3:0]          w_lane_en;
  logic [ADDR_W-1:0]   w_wa [4];
  logic [ADDR_W-1:0]   w_ra [4];
  logic [31:0]         w_ram_word;
  logic [c_IDX_W-1:0]  w_top_idx;
  logic                unused_addr_hi;

  // Bit 32 of both addresses is outside the decoded space.
  assign unused_addr_hi = dmem_store_addr[32] ^ dmem_load_addr[32];

  assign w_sa      = dmem_store_addr[31:0];
  assign w_la      = dmem_load_addr[31:0];
  assign w_run     = (state_q == S_RUN);
  assign w_st_stk  = (w_sa == 32'd0);
  assign w_st_stat = (w_sa == STATUS_ADDR);
  assign w_ld_stk  = (w_la == 32'd0);
  assign w_ld_stat = (w_la == STATUS_ADDR);

  assign w_push     = c_dmem_store & w_run & w_st_stk;
  assign w_pop      = c_dmem_load & w_ld_stk;
  assign w_ram_we   = c_dmem_store & w_run & ~w_st_stk & ~w_st_stat;
  assign w_stat_we  = c_dmem_store & w_run & w_st_stat;
  assign w_full     = (sp_q == c_FULL);
  assign w_empty    = (sp_q == '0);
  assign w_pass_tok = w_stat_we & (dmem_store_data == PASS_CODE);
  assign w_fail_tok = w_stat_we & (dmem_store_data == FAIL_CODE);
  assign w_top_idx  = c_IDX_W'(sp_q - c_SP_W'(1));

  // Widths 4..7 without bit1 fall into the half-word case.
  assign w_lane_en = {dmem_store_width[1], dmem_store_width[1], |dmem_store_width, 1'b1};

  generate
    for (genvar g = 0; g < 4; g++) begin : g_lane
      assign w_wa[g] = w_sa[ADDR_W-1:0] + ADDR_W'(g);
      assign w_ra[g] = w_la[ADDR_W-1:0] + ADDR_W'(g);
      assign w_ram_word[8*g +: 8] = mem_q[w_ra[g]];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_ram_we && w_lane_en[i]) begin
        mem_q[w_wa[i]] <= dmem_store_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_full) begin
      stk_q[sp_q[c_IDX_W-1:0]] <= dmem_store_data;
    end
  end

  always_comb begin
    dmem_load_data = w_ram_word;
    if (w_ld_stk) begin
      dmem_load_data = w_empty ? 32'd0 : stk_q[w_top_idx];
    end else if (w_ld_stat) begin
      dmem_load_data = {28'd0, timeout, fail, pass, done};
    end
  end

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    cyc_d   = cyc_q;
    pcnt_d  = pcnt_q;
    // An attempted push (even a dropped one) suppresses a concurrent pop.
    if (w_push) begin
      if (w_full) begin
        ovf_d = 1'b1;
      end else begin
        sp_d = sp_q + c_SP_W'(1);
      end
    end else if (w_pop && !w_empty) begin
      sp_d = sp_q - c_SP_W'(1);
    end
    if (state_q == S_RUN) begin
      cyc_d = cyc_q + 32'd1;
      if (w_pass_tok) begin
        pcnt_d = pcnt_q + c_PC_W'(1);
        if (pcnt_q == c_PC_LAST) begin
          state_d = S_PASS;
        end
      end else if (w_fail_tok) begin
        state_d = S_FAIL;
      end else if (cyc_q >= c_TO_LAST) begin
        state_d = S_TOUT;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_RUN;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      cyc_q   <= 32'd0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      cyc_q   <= cyc_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign sp        = sp_q;
  assign stack_ovf = ovf_q;
  assign done      = (state_q != S_RUN);
  assign pass      = (state_q == S_PASS);
  assign fail      = (state_q == S_FAIL);
  assign timeout   = (state_q == S_TOUT);
  assign cycle_cnt = cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dmem_mmio_ctrl - directed and randomized bench with a behavioural model
// of RAM, stack and status FSM.                               Rev 1.0
// ============================================================================
module tb_dmem_mmio_ctrl;

  localparam logic [31:0] STATUS = 32'h1001200C;
  localparam logic [31:0] PASSC  = 32'h00400000;
  localparam logic [31:0] FAILC  = 32'h00080000;
  localparam int          DEPTH  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, c_dmem_store, ld;
  logic [2:0]  w;
  logic [31:0] sd;
  logic [32:0] sa, la;
  logic [31:0] ld_data, cyc;
  logic [4:0]  sp;
  logic        ovf, done, pass, fail, tout;

  logic        t_rstn, t_st;
  logic [31:0] t_d;
  logic [32:0] t_a;
  logic [31:0] t_ld, t_cyc;
  logic [4:0]  t_sp;
  logic        t_ovf, t_done, t_pass, t_fail, t_tout;

  dmem_mmio_ctrl u_dut (
    .clk(clk), .rstn(rstn), .c_dmem_store(c_dmem_store), .dmem_store_width(w),
    .dmem_store_data(sd), .dmem_store_addr(sa), .c_dmem_load(ld), .dmem_load_addr(la),
    .dmem_load_data(ld_data), .sp(sp), .stack_ovf(ovf), .done(done), .pass(pass),
    .fail(fail), .timeout(tout), .cycle_cnt(cyc)
  );

  dmem_mmio_ctrl #(.ADDR_W(8), .TIMEOUT(8), .PASS_NEEDED(1)) u_t (
    .clk(clk), .rstn(t_rstn), .c_dmem_store(t_st), .dmem_store_width(3'd2),
    .dmem_store_data(t_d), .dmem_store_addr(t_a), .c_dmem_load(1'b0), .dmem_load_addr(33'd0),
    .dmem_load_data(t_ld), .sp(t_sp), .stack_ovf(t_ovf), .done(t_done), .pass(t_pass),
    .fail(t_fail), .timeout(t_tout), .cycle_cnt(t_cyc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sparse byte RAM, stack as a queue, FSM as a state number
  logic [7:0]  m_mem [int];
  logic [31:0] m_stk [$];
  bit          m_ovf;
  int unsigned m_cyc;
  int          m_pcnt;
  int          m_st;   // 0 run, 1 pass, 2 fail, 3 timeout

  function automatic void model_reset();
    m_stk.delete();
    m_ovf  = 1'b0;
    m_cyc  = 0;
    m_pcnt = 0;
    m_st   = 0;
  endfunction

  function automatic void model_edge();
    logic [31:0] a, l;
    bit run;
    int nb;
    a = sa[31:0];
    l = la[31:0];
    run = (m_st == 0);
    if (c_dmem_store && run && a == 32'd0) begin
      if (m_stk.size() == DEPTH) m_ovf = 1'b1;
      else m_stk.push_back(sd);
    end else if (ld && l == 32'd0 && m_stk.size() > 0) begin
      void'(m_stk.pop_back());
    end
    if (c_dmem_store && run && a != 32'd0 && a != STATUS) begin
      nb = (w == 3'd0) ? 1 : (w[1] ? 4 : 2);
      for (int i = 0; i < nb; i++) m_mem[int'((a + 32'(i)) & 32'hFFFFF)] = sd[8*i +: 8];
    end
    if (run) begin
      if (c_dmem_store && a == STATUS && sd == PASSC) begin
        m_pcnt++;
        if (m_pcnt == 2) m_st = 1;
      end else if (c_dmem_store && a == STATUS && sd == FAILC) begin
        m_st = 2;
      end else if (m_cyc >= 32'd3199999) begin
        m_st = 3;
      end
      m_cyc++;
    end
  endfunction

  function automatic bit exp_load(output logic [31:0] v);
    logic [31:0] l;
    int k;
    l = la[31:0];
    v = 32'd0;
    exp_load = 1'b1;
    if (l == 32'd0) begin
      if (m_stk.size() > 0) v = m_stk[$];
    end else if (l == STATUS) begin
      v = {28'd0, m_st == 3, m_st == 2, m_st == 1, m_st != 0};
    end else begin
      for (int i = 0; i < 4; i++) begin
        k = int'((l + 32'(i)) & 32'hFFFFF);
        if (!m_mem.exists(k)) exp_load = 1'b0;
        else v[8*i +: 8] = m_mem[k];
      end
    end
  endfunction

  always @(negedge clk) begin
    logic [31:0] e;
    bit k;
    k = exp_load(e);
    if (k) check("load_data", ld_data, e);
    check("sp", 32'(sp), 32'(m_stk.size()));
    check("stack_ovf", 32'(ovf), 32'(m_ovf));
    check("done", 32'(done), 32'(m_st != 0));
    check("pass", 32'(pass), 32'(m_st == 1));
    check("fail", 32'(fail), 32'(m_st == 2));
    check("timeout", 32'(tout), 32'(m_st == 3));
    check("cycle_cnt", cyc, m_cyc);
  end

  task automatic step();
    @(posedge clk);
    if (rstn) model_edge();
    #1;
  endtask

  task automatic drv(input bit st, input logic [2:0] wd, input logic [31:0] d,
                     input logic [31:0] a, input bit l, input logic [31:0] lad);
    c_dmem_store = st; w = wd; sd = d; sa = {1'b0, a}; ld = l; la = {1'b0, lad};
  endtask

  task automatic idle();
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'h400);
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  function automatic logic [31:0] rand_ram_addr();
    logic [19:0] lo;
    if ($urandom_range(0, 1) == 0) lo = 20'h00300 + 20'($urandom_range(0, 63));
    else lo = 20'hFFFFC + 20'($urandom_range(0, 7));
    return {12'($urandom), lo};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; t_rstn = 1'b0; t_st = 1'b0; t_d = 32'd0; t_a = 33'd0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_sp", 32'(sp), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_flags", {28'd0, tout, fail, pass, done}, 32'd0);
    check("rst_cyc", cyc, 32'd0);
    rstn = 1'b1;
    step();
    check("cyc_first", cyc, 32'd1);

    // byte lanes
    drv(1'b1, 3'd2, 32'hA1B2C3D4, 32'h100, 1'b0, 32'h400); step();
    drv(1'b1, 3'd1, 32'h0000EEFF, 32'h101, 1'b0, 32'h400); step();
    drv(1'b1, 3'd0, 32'h00000077, 32'h103, 1'b0, 32'h400); step();
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 32'h100);
    #1 check("byte_lanes", ld_data, 32'h77EEFFD4);
    step();

    // no forwarding
    drv(1'b1, 3'd2, 32'h01020304, 32'h104, 1'b0, 32'h400); step();
    drv(1'b1, 3'd2, 32'h55667788, 32'h104, 1'b1, 32'h104);
    #1 check("no_forward", ld_data, 32'h01020304);
    step();

    // wraparound
    drv(1'b1, 3'd2, 32'h11223344, 32'hFFFFE, 1'b0, 32'h400); step();
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'hFFFFE);
    #1 check("wrap_word", ld_data, 32'h11223344);
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'h0);
    #1 check("wrap_empty_stack", ld_data, 32'd0);
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'hFFFFF);
    #1 check("wrap_byte0", {8'd0, ld_data[23:0]}, 32'h00112233);
    step();

    // stack
    drv(1'b1, 3'd2, 32'd5, 32'd0, 1'b0, 32'h400); step();
    drv(1'b1, 3'd2, 32'd6, 32'd0, 1'b0, 32'h400); step();
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 32'd0);
    #1 check("pop_6", ld_data, 32'd6);
    step(); check("pop_sp1", 32'(sp), 32'd1);
    #1 check("pop_5", ld_data, 32'd5);
    step(); check("pop_sp0", 32'(sp), 32'd0);
    #1 check("pop_empty", ld_data, 32'd0);
    step(); check("pop_sp_stays0", 32'(sp), 32'd0);
    for (int i = 1; i <= 17; i++) begin
      drv(1'b1, 3'd2, 32'(i), 32'd0, 1'b0, 32'h400); step();
    end
    check("ovf_sp", 32'(sp), 32'd16);
    check("ovf_flag", 32'(ovf), 32'd1);
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 32'd0);
    repeat (13) step();
    check("sp_3", 32'(sp), 32'd3);
    drv(1'b1, 3'd2, 32'h0000CAFE, 32'd0, 1'b1, 32'd0);
    #1 check("pushpop_data", ld_data, 32'd3);
    step(); check("pushpop_sp", 32'(sp), 32'd4);
    idle();

    // randomized traffic, staying in RUN
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [31:0] a, d, l;
      r = $urandom_range(0, 9);
      d = $urandom;
      a = rand_ram_addr();
      c_dmem_store = 1'b0;
      if (r <= 3) begin
        c_dmem_store = 1'b1;
      end else if (r <= 5) begin
        c_dmem_store = 1'b1; a = 32'd0;
      end else if (r == 6) begin
        c_dmem_store = 1'b1; a = STATUS;
        if (d == PASSC || d == FAILC) d = d ^ 32'd1;
      end
      r = $urandom_range(0, 9);
      l = (r < 4) ? 32'd0 : ((r == 4) ? STATUS : rand_ram_addr());
      w  = 3'($urandom_range(0, 7));
      sd = d;
      sa = {1'($urandom), a};
      la = {1'($urandom), l};
      ld = 1'($urandom_range(0, 1));
      step();
    end
    idle();
    step();

    // pass
    drv(1'b1, 3'd2, 32'h5A5A5A5A, 32'h200, 1'b0, 32'h400); step();
    drv(1'b1, 3'd2, PASSC, STATUS, 1'b0, 32'h400); step();
    drv(1'b1, 3'd2, 32'h12345678, 32'h204, 1'b0, 32'h400); step();
    drv(1'b1, 3'd2, 32'h00000000, STATUS, 1'b0, 32'h400); step();
    check("pass_after_one", 32'(pass), 32'd0);
    drv(1'b1, 3'd2, PASSC, STATUS, 1'b0, 32'h400);
    #1 check("pass_pre_edge", 32'(pass), 32'd0);
    step();
    check("pass_set", 32'(pass), 32'd1);
    check("pass_done", 32'(done), 32'd1);
    drv(1'b1, 3'd2, 32'hFFFFFFFF, 32'h200, 1'b0, 32'h400); step();
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'h200);
    #1 check("pass_ram_blocked", ld_data, 32'h5A5A5A5A);
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, STATUS);
    #1 check("pass_status_word", ld_data, 32'h00000003);
    step();
    idle();

    // reset mid-run with sp = 3 and one pass token pending
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 3'd2, 32'h100 + 32'(i), 32'd0, 1'b0, 32'h400); step();
    end
    drv(1'b1, 3'd2, PASSC, STATUS, 1'b0, 32'h400); step();
    idle();
    check("pending_sp", 32'(sp), 32'd3);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    check("midrst_sp", 32'(sp), 32'd0);
    check("midrst_flags", {27'd0, ovf, tout, fail, pass, done}, 32'd0);
    check("midrst_cyc", cyc, 32'd0);
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'h100);
    @(posedge clk);
    #1 check("ram_retained", ld_data, 32'h77EEFFD4);
    rstn = 1'b1;
    drv(1'b1, 3'd2, PASSC, STATUS, 1'b0, 32'h400); step();
    check("pcnt_cleared", 32'(pass), 32'd0);
    drv(1'b1, 3'd2, PASSC, STATUS, 1'b0, 32'h400); step();
    check("pass_after_rst", 32'(pass), 32'd1);
    idle();

    // fail
    do_reset();
    drv(1'b1, 3'd2, FAILC, STATUS, 1'b0, 32'h400);
    #1 check("fail_pre_edge", 32'(fail), 32'd0);
    step();
    check("fail_set", 32'(fail), 32'd1);
    check("fail_done", 32'(done), 32'd1);
    idle();
    step();

    // timeout with TIMEOUT = 8
    t_rstn = 1'b1;
    repeat (7) step();
    check("tout_c7_flag", 32'(t_tout), 32'd0);
    check("tout_c7_cnt", t_cyc, 32'd7);
    step();
    check("tout_flag", 32'(t_tout), 32'd1);
    check("tout_cnt", t_cyc, 32'd8);
    check("tout_done", 32'(t_done), 32'd1);
    repeat (3) step();
    check("tout_cnt_frozen", t_cyc, 32'd8);

    // pass token in the last run cycle beats the timeout
    #2 t_rstn = 1'b0;
    @(posedge clk);
    #1 t_rstn = 1'b1;
    repeat (7) step();
    t_st = 1'b1; t_d = PASSC; t_a = {1'b0, STATUS};
    step();
    t_st = 1'b0;
    check("race_pass", 32'(t_pass), 32'd1);
    check("race_tout", 32'(t_tout), 32'd0);
    check("race_cnt", t_cyc, 32'd8);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_mmio_ctrl.md
# dmem_mmio_ctrl

Data-memory and MMIO status controller attached directly to the RV32IMC_3P data port. It consumes the core's store and load strobes. It provides a little-endian byte-addressable RAM with byte, half and word stores and combinational word loads. It also provides a hardware push/pop stack aliased at address 0 and a test-status register at 0x1001200C that drives a pass/fail/timeout state machine. It is the synthesizable replacement for the behavioural memory and checker used around the core.

## Interface

**Parameters**
- `ADDR_W`, default 20: byte-address bits decoded for RAM (RAM size is 2^ADDR_W bytes).
- `STACK_DEPTH`, default 16: stack words, a power of 2.
- `STATUS_ADDR`, default 32'h1001200C: status MMIO address.
- `PASS_CODE`, default 32'h00400000: pass token.
- `FAIL_CODE`, default 32'h00080000: fail token.
- `PASS_NEEDED`, default 2: pass tokens required to finish.
- `TIMEOUT`, default 3200000: run-cycle limit.

**Ports**
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rstn`, input, 1: asynchronous, active-low reset.
- `c_dmem_store`, input, 1: store strobe.
- `dmem_store_width`, input, 3: 0 = byte, 1 = half, bit1 set = word.
- `dmem_store_data`, input, 32: store data, with byte 0 in bits [7:0].
- `dmem_store_addr`, input, 33: store byte address; only bits [31:0] are decoded.
- `c_dmem_load`, input, 1: load strobe.
- `dmem_load_addr`, input, 33: load byte address; only bits [31:0] are decoded.
- `dmem_load_data`, output, 32: combinational load word.
- `sp`, output, log2(STACK_DEPTH)+1: stack occupancy in words.
- `stack_ovf`, output, 1: sticky flag; a push was made while the stack was full.
- `done`, output, 1: the FSM is in a terminal state.
- `pass`, output, 1: the FSM is in PASS.
- `fail`, output, 1: the FSM is in FAIL.
- `timeout`, output, 1: the FSM is in TOUT.
- `cycle_cnt`, output, 32: number of cycles spent in RUN.

## Operation

**Address decode** (on bits [31:0]):
- Address == 0: stack.
- Address == STATUS_ADDR: status register.
- Any other address: RAM at byte index addr[ADDR_W-1:0].

**RAM store**
- Writes byte lanes at offsets +0, +1 (width != 0), and +2/+3 (width[1] set).
- Any alignment is accepted.
- Lane addresses wrap modulo 2^ADDR_W.
- Width 4..7 with bit1 clear is treated as half.

**RAM load**
- `dmem_load_data` = {mem[a+3], mem[a+2], mem[a+1], mem[a]}, with wraparound, regardless of the `c_dmem_load` strobe.

**Stack push** (store to address 0)
- Writes `dmem_store_data` to `stk[sp]` and increments sp.
- If sp == STACK_DEPTH: the push is dropped and `stack_ovf` is set.

**Stack pop** (load from address 0 with `c_dmem_load`)
- `dmem_load_data` = `stk[sp-1]`; sp decrements.
- If sp == 0: the data is 0 and sp stays at 0.
- Load address 0 without the strobe still shows `stk[sp-1]`, or 0 if the stack is empty.

**Simultaneous push and pop**
- The push takes priority: sp increments and the pop's decrement is suppressed.
- The load returns the pre-edge top of stack.

**Status register**
- Stores are never written to RAM. Loads from it return {28'b0, timeout, fail, pass, done}.

**Status FSM**
- States: RUN, PASS, FAIL, TOUT. Reset state is RUN.
- RUN:
  - Store of PASS_CODE: `pass_cnt` increments; the PASS_NEEDED-th token moves the FSM to PASS.
  - Store of FAIL_CODE: moves to FAIL.
  - Any other data: ignored.
  - `cycle_cnt` == TIMEOUT-1 with no token this cycle: moves to TOUT.
  - A token arriving in the TIMEOUT-1 cycle wins over the timeout.
- PASS, FAIL and TOUT are terminal until reset.
  - In these states all RAM, stack and status writes are blocked.
  - Loads keep working.
  - `cycle_cnt` holds its value.

**Reset**
- Asynchronous and active-low; it may be asserted at any cycle, including mid-operation.
- The FSM returns to RUN; `sp`, `stack_ovf`, `cycle_cnt` and `pass_cnt` all go to 0.
- RAM and stack contents are not reset.

## Timing

- Stores commit at the rising edge of `clk` on which `c_dmem_store` is high.
- Loads are zero latency. There is no store-to-load forwarding: a same-cycle load of the address being stored returns the old data.
- `sp`, `stack_ovf`, `done`, `pass`, `fail`, `timeout` and `cycle_cnt` are registered outputs; they change one edge after the causing strobe.
- Output reset values:
  - `sp`, `stack_ovf`, `done`, `pass`, `fail`, `timeout`, `cycle_cnt`: all 0.
  - `dmem_load_data`: follows the address (it is combinational).
- `cycle_cnt` increments every cycle in RUN while `rstn` = 1.
  - The first edge after reset is released gives `cycle_cnt` = 1.
  - It freezes on entry to a terminal state.

## Test plan

- **Byte lanes.** Word store of 0xA1B2C3D4 at 0x100, then a half store of 0xEEFF at 0x101, then a byte store of 0x77 at 0x103; load 0x100 -> 0x77EEFFD4.
- **Wraparound.** Word store of 0x11223344 at 0xFFFFE (ADDR_W = 20); load 0xFFFFE -> 0x11223344; load 0x0 without the strobe -> empty-stack value 0; byte 0x00000 reads as 0x22 via a load at 0xFFFFF (upper bits from RAM).
- **Stack.**
  - Push 5 and 6, then pop -> 6, `sp` = 1; pop -> 5, `sp` = 0; pop -> 0, `sp` = 0.
  - Push 17 values into depth 16 -> `sp` = 16, `stack_ovf` = 1.
  - Push and pop in the same cycle with sp = 3 -> load returns `stk[2]`, `sp` = 4.
- **Pass.** Store 0x00400000 to 0x1001200C twice with other stores between -> `pass` = `done` = 1 on the edge after the second store; a following RAM store at 0x200 leaves RAM unchanged.
- **Fail and timeout.**
  - Store 0x00080000 -> `fail` = 1 one edge later.
  - With TIMEOUT = 8 and no tokens -> `timeout` = 1 with `cycle_cnt` = 8.
  - A pass token arriving in cycle 7 with PASS_NEEDED = 1 -> PASS, not TOUT.
- **Reset mid-run.** Assert `rstn` = 0 asynchronously between edges with sp = 3 and PASS pending -> `sp`, `pass_cnt`, `cycle_cnt` and all flags read 0 immediately; RAM word at 0x100 is retained.
